// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package ifetch_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int unsigned INST_BYTES = 4;

  // One prefetch buffer entry: fetch address and the word returned for it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fb_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; flush beats push, pop may coincide.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fb_entry_t        wdata,
  output fb_entry_t        rdata,
  output logic [CNT_W-1:0] count
);

  fb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through a valid occupancy.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: owns the PC, fills the prefetch buffer, steers on redirect.
// Optional IFETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FB_DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(FB_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  output logic [CNT_W-1:0] fb_count
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_flushed
`endif
);

  logic [31:0] pc_q, pc_d;
  logic        pop_c, push_c;
  fb_entry_t   wr_entry, head;
  logic [CNT_W-1:0] count;
  logic        unused_rpc_lo;

  // Redirect targets are word aligned; the byte offset is dropped.
  assign unused_rpc_lo = ^redirect_pc[1:0];

  // Handshake and fetch decision; a full buffer still accepts when the head leaves.
  always_comb begin
    pop_c  = (count != '0) && inst_ready;
    push_c = !redirect_valid && ((count < CNT_W'(FB_DEPTH)) || pop_c);
    pc_d   = pc_q;
    if (redirect_valid)  pc_d = {redirect_pc[31:2], 2'b00};
    else if (push_c)     pc_d = pc_q + 32'(INST_BYTES);
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign wr_entry.pc   = pc_q;
  assign wr_entry.inst = imem_rdata;

  fetch_fifo #(.DEPTH(FB_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (count)
  );

  assign imem_addr  = pc_q;
  assign fb_count   = count;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? head.pc   : 32'h0000_0000;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;

  // Pushes, and entries left behind (after any same-cycle pop) at each redirect.
  always_comb begin
    fetched_d = fetched_q + 32'(push_c);
    flushed_d = flushed_q;
    if (redirect_valid) flushed_d = flushed_q + 32'(count - CNT_W'(pop_c));
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_ifetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, inst_ready, inst_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic [1:0]  fb_count;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RPC), .FB_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fb_count       (fb_count)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Combinational instruction memory.
  always_comb imem_rdata = mem_word(imem_addr);

  int total = 0;
  int bad   = 0;

  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_fetched, m_flushed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [31:0] e_pc, e_inst;
    e_pc = 32'h0; e_inst = 32'h0;
    if (m_q.size() > 0) {e_pc, e_inst} = m_q[0];
    check("m_valid", 32'(inst_valid), 32'(m_q.size() > 0));
    check("m_inst", inst, e_inst);
    check("m_inst_pc", inst_pc, e_pc);
    check("m_count", 32'(fb_count), 32'(m_q.size()));
    check("m_addr", imem_addr, m_pc);
`ifdef IFETCH_PERF_CNT_EN
    check("m_fetched", perf_fetched, m_fetched);
    check("m_flushed", perf_flushed, m_flushed);
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic pop;
    rst = r; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    if (r) begin
      m_q.delete();
      m_pc = RPC;
      m_fetched = 0;
      m_flushed = 0;
    end else begin
      pop = (m_q.size() > 0) && rdy;
      if (rv) begin
        m_flushed += 32'(m_q.size()) - 32'(pop);
        m_q.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_q.size() < DEPTH) begin
          m_q.push_back({m_pc, mem_word(m_pc)});
          m_pc += 4;
          m_fetched++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    // Streaming with decode always ready.
    step(1, 0, 0, 1);
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_count", 32'(fb_count), 0);
    check("rst_addr", imem_addr, RPC);
    check("rst_inst", inst, 0);
    step(0, 0, 0, 1);
    check("s0_pc", inst_pc, 32'h0);
    check("s0_inst", inst, 32'h1000_0000);
    step(0, 0, 0, 1);
    check("s1_pc", inst_pc, 32'h4);
    check("s1_inst", inst, 32'h1000_0001);
    step(0, 0, 0, 1);
    check("s2_pc", inst_pc, 32'h8);
    check("s2_inst", inst, 32'h1000_0002);

    // Stall fills the buffer, release drains in order.
    step(1, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0);
    check("stall_count", 32'(fb_count), 2);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_head", inst_pc, 32'h0);
    step(0, 0, 0, 1);
    check("rel_head1", inst_pc, 32'h4);
    step(0, 0, 0, 1);
    check("rel_head2", inst_pc, 32'h8);
    check("rel_count", 32'(fb_count), 2);

    // Unaligned redirect together with the pop of 0x8.
    step(0, 1, 32'h103, 1);
    check("rd2_count", 32'(fb_count), 0);
    check("rd2_addr", imem_addr, 32'h100);
    check("rd2_valid", 32'(inst_valid), 0);
    step(0, 0, 0, 1);
    check("rd2_tgt", inst_pc, 32'h100);

    // Redirect with a full buffer and no pop.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("full_addr", imem_addr, 32'h8);
    step(0, 1, 32'h100, 0);
    check("rd_valid", 32'(inst_valid), 0);
    check("rd_pc", inst_pc, 0);
    step(0, 0, 0, 0);
    check("rd_tgt_pc", inst_pc, 32'h100);
    check("rd_tgt_inst", inst, 32'h1000_0040);

    // Reset beats redirect and handshake.
    step(0, 0, 0, 0);
    step(1, 1, 32'h200, 1);
    check("mrst_valid", 32'(inst_valid), 0);
    check("mrst_count", 32'(fb_count), 0);
    check("mrst_addr", imem_addr, RPC);
    step(0, 0, 0, 1);
    check("mrst_first", inst_pc, RPC);
    check("mrst_fvalid", 32'(inst_valid), 1);

    // Ten pushes, then a redirect discarding two entries.
    step(1, 0, 0, 1);
    repeat (9) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("perf_pre_count", 32'(fb_count), 2);
    step(0, 1, 32'h40, 0);
`ifdef IFETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 10);
    check("perf_flushed", perf_flushed, 2);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), $urandom(),
           ($urandom_range(3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch front-end of the MIPS core; the initiator side of the combinational instruction memory. It owns the PC, drives the word address to instruction memory every cycle and captures the returned word into a small prefetch buffer. It presents fetched instructions to decode over a valid/ready handshake, and flushes and re-steers on branch/jump redirects.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FB_DEPTH, 2, prefetch buffer entries; must be a power of two and ≥2.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
imem_addr  output  32  byte address to instruction memory; equals the PC register, combinational from the register.
imem_rdata  input  32  instruction word returned combinationally for imem_addr.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_pc  input  32  redirect target byte address.
inst_valid  output  1  buffer head holds a valid instruction.
inst_ready  input  1  decode accepts the head this cycle.
inst  output  32  head instruction; 32'h0000_0000 (nop) when inst_valid=0.
inst_pc  output  32  byte address of the head instruction; 0 when inst_valid=0.
fb_count  output  $clog2(FB_DEPTH)+1  current buffer occupancy.

Behaviour:
- Reset (clk edge with rst=1): pc←RESET_PC, buffer empty, inst_valid=0, inst=0, inst_pc=0, fb_count=0. Reset overrides redirect and handshake in the same cycle.
- pop = inst_valid & inst_ready. push = !redirect_valid & (fb_count<FB_DEPTH | pop).
- On push: enqueue {pc, imem_rdata}; pc←pc+4, modulo 2^32 with no saturation.
- No push: pc holds and imem_addr is stable.
- Full buffer with a pop in the same cycle: push still occurs, sustaining 1 instruction/cycle.
- Latency: an instruction fetched at cycle N is visible on inst/inst_pc at N+1. After reset release at cycle N, first inst_valid occurs at N+1 with inst_pc=RESET_PC.
- Redirect (highest priority after reset):
  - A pop in the same cycle counts as accepted.
  - All remaining entries are flushed and fb_count←0; no push occurs.
  - pc←{redirect_pc[31:2],2'b00}; low two bits are silently discarded.
  - Redirect-target instruction is fetched at N+1 and visible at N+2.
  - inst_valid=0 at N+1. No pre-redirect entry may appear after the redirect edge.
- Back-to-back redirects: the later one wins; each flushes.
- Buffer is FIFO ordered. Entries are never dropped or duplicated except by flush.
- Empty buffer: inst_valid=0, and inst_ready is ignored.
- No internal state machine beyond the buffer pointers: wrap-around read/write pointers plus occupancy counter. Pointer wrap is at FB_DEPTH.

Optional Feature:
Macro IFETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetched[31:0] (count of pushes) and perf_flushed[31:0] (cumulative count of entries discarded by redirects, adding the post-pop occupancy at each redirect). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ifetch_pkg holds:
  - fb_entry_t, a packed struct {logic [31:0] pc; logic [31:0] inst}.
  - NOP_INST=32'h0000_0000.
  - INST_BYTES=4.
- Sub-module fetch_fifo: synchronous FIFO of fb_entry_t, parameterised by depth, with push/pop/flush and count. Flush takes priority over push; a pop in the same cycle as a flush is permitted. ifetch_unit holds the PC and the steering logic.

Test Plan:
- Reset then inst_ready=1, memory word k = 0x1000_0000+k → from cycle 1: inst_pc 0x0,0x4,0x8… with inst 0x1000_0000,…0001,…0002, one per cycle, no bubbles.
- inst_ready=0 for 6 cycles → fb_count reaches 2 and holds; imem_addr frozen at 0x8. Release → 0x0,0x4,0x8 in order with no loss or duplication.
- Redirect to 0x100 while buffer full (0x0,0x4) → inst_valid=0 next cycle; next valid inst_pc=0x100 two cycles after the redirect; 0x0/0x4 never emitted.
- Redirect to 0x103 in the same cycle as a pop of 0x8 → pop of 0x8 accepted; next fetch at 0x100; fb_count=0 after the edge.
- Assert rst mid-stream with buffer full and redirect_valid=1 → all outputs 0 after the edge; next first inst_pc=RESET_PC.
- With IFETCH_PERF_CNT_EN: 10 pushes then a redirect with 2 buffered entries and no pop → perf_fetched=10, perf_flushed=2.
